// File: rtl/neosd_pkg.sv
// Shared types and constants for the neosd CMD-line transmitter and receiver.
package neosd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_WAIT_START,
    RX_RECV,
    RX_CHECK
  } RX_STATE;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_SHORT,
    RESP_LONG
  } RESP_MODE;

  localparam int RESP_SHORT_BITS = 48;
  localparam int RESP_LONG_BITS  = 136;

  function automatic logic [7:0] resp_bits(input RESP_MODE mode);
    return (mode == RESP_LONG) ? 8'(RESP_LONG_BITS) : 8'(RESP_SHORT_BITS);
  endfunction

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, shared by the CMD transmitter and receiver.
module neosd_crc7 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic       fb;

  assign fb    = bit_i ^ crc_q[6];
  assign crc_o = crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
  end

endmodule

// File: rtl/neosd_cmd_rx.sv
// SD CMD-line response receiver: start-bit hunt with NCR timeout, 48/136-bit shift-in,
// CRC7 and framing check.
//   state         | meaning
//   RX_IDLE       | disarmed, status outputs holding
//   RX_WAIT_START | armed, counting strobes until a start bit or timeout
//   RX_RECV       | shifting in response bits
//   RX_CHECK      | one-cycle result/done slot
module neosd_cmd_rx
  import neosd_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_en_i,
  input  logic         sd_cmd_i,
  input  logic         start_i,
  input  logic         long_i,
  input  logic         crc_chk_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         timeout_o,
  output logic         crc_err_o,
  output logic         frame_err_o,
  output logic [5:0]   idx_o,
  output logic [127:0] resp_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  RX_STATE        state_q;
  RESP_MODE       mode_q;
  logic           crc_chk_q;
  logic [TW-1:0]  ticks_q, ticks_d;
  logic [7:0]     cnt_q;
  logic [135:0]   shift_q, shift_d;
  logic           tx_q;
  logic           busy_q, done_q, timeout_q, crc_err_q, frame_err_q;
  logic [5:0]     idx_q;
  logic [127:0]   resp_q;

  logic           accept, is_long, crc_clr, crc_en;
  logic [7:0]     bit_idx, crc_top;
  logic [6:0]     crc;
  logic           unused_shift_msb;

  // The CHECK cycle is the done cycle, so a start arriving with done_o is accepted.
  assign accept   = start_i && (state_q == RX_IDLE || state_q == RX_CHECK);
  assign is_long  = (mode_q == RESP_LONG);
  assign bit_idx  = resp_bits(mode_q) - 8'd1 - cnt_q;
  assign crc_top  = is_long ? 8'd127 : 8'd46;
  assign ticks_d  = ticks_q + TW'(1);
  assign shift_d  = {shift_q[134:0], sd_cmd_i};

  // Start bit is always fed as 0; for R2 the CRC restarts at bit 128 so it covers 127..8 only.
  assign crc_clr  = accept ||
                    (state_q == RX_RECV && clk_en_i && is_long && bit_idx == 8'd128);
  assign crc_en   = clk_en_i &&
                    ((state_q == RX_WAIT_START && !sd_cmd_i) ||
                     (state_q == RX_RECV && bit_idx >= 8'd8 && bit_idx <= crc_top));

  assign unused_shift_msb = shift_q[135];

  neosd_crc7 u_crc7 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (sd_cmd_i),
    .crc_o (crc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_IDLE;
      mode_q      <= RESP_SHORT;
      crc_chk_q   <= 1'b0;
      ticks_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      idx_q       <= '0;
      resp_q      <= '0;
    end else if (abort_i) begin
      state_q <= RX_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mode_q      <= long_i ? RESP_LONG : RESP_SHORT;
        crc_chk_q   <= crc_chk_i;
        ticks_q     <= '0;
        cnt_q       <= '0;
        shift_q     <= '0;
        tx_q        <= 1'b0;
        timeout_q   <= 1'b0;
        crc_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
        idx_q       <= '0;
        resp_q      <= '0;
        busy_q      <= 1'b1;
        state_q     <= RX_WAIT_START;
      end else begin
        case (state_q)
          RX_WAIT_START: begin
            if (clk_en_i) begin
              if (!sd_cmd_i) begin
                cnt_q   <= 8'd1;
                state_q <= RX_RECV;
              end else begin
                ticks_q <= ticks_d;
                if (ticks_d == TW'(TIMEOUT)) begin
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= RX_CHECK;
                end
              end
            end
          end
          RX_RECV: begin
            if (clk_en_i) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 8'd1;
              if (cnt_q == 8'd1) tx_q <= sd_cmd_i;
              // After the end bit, shift_d[j] holds response bit j for every j below the start bit.
              if (bit_idx == 8'd0) begin
                frame_err_q <= tx_q | ~sd_cmd_i;
                crc_err_q   <= crc_chk_q & (crc != shift_d[7:1]);
                if (is_long) begin
                  idx_q  <= shift_d[133:128];
                  resp_q <= {shift_d[127:1], 1'b0};
                end else begin
                  idx_q  <= shift_d[45:40];
                  resp_q <= {96'd0, shift_d[39:8]};
                end
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= RX_CHECK;
              end
            end
          end
          RX_CHECK: state_q <= RX_IDLE;
          default:  state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign crc_err_o   = crc_err_q;
  assign frame_err_o = frame_err_q;
  assign idx_o       = idx_q;
  assign resp_o      = resp_q;

endmodule
